// File: rtl/mem_refill_arbiter_pkg.sv
// Shared encodings for the I/D refill arbiter: FSM states, burst owner,
// and the line-offset arithmetic derived from the burst length.
package mem_refill_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Byte-offset bits inside one 32-bit word.
    localparam int unsigned WORD_OFF_W = 2;

    // Number of address bits covered by one line of line_words words.
    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words) + WORD_OFF_W;
    endfunction

    // Line base address: the offset bits inside the line are cleared.
    function automatic logic [31:0] line_base(input logic [31:0] addr,
                                              input int unsigned line_words);
        return addr & ~((32'd1 << off_w(line_words)) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_refill_arbiter_beat_seq.sv
// Beat sequencer for one line burst: a latency counter that holds each word
// address for MEM_LAT cycles and a beat counter that walks the line.
module mem_beat_seq
    import mem_refill_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          en_i,
    output logic [$clog2(LINE_WORDS)-1:0] beat_o,
    output logic                          last_cyc_o,
    output logic                          last_beat_o
);

    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
    localparam int unsigned LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    assign last_cyc_o  = (lat_q == LAT_W'(MEM_LAT - 1));
    assign last_beat_o = (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign beat_o      = beat_q;

    // Next counter values: restart on a grant, otherwise advance while the
    // burst runs; the beat counter wraps to 0 only after the final beat.
    always_comb begin
        lat_d  = lat_q;
        beat_d = beat_q;
        if (start_i) begin
            lat_d  = '0;
            beat_d = '0;
        end else if (en_i) begin
            if (last_cyc_o) begin
                lat_d  = '0;
                beat_d = beat_q + 1'b1;
            end else begin
                lat_d = lat_q + 1'b1;
            end
        end
    end

    // Counter registers, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_q  <= '0;
            beat_q <= '0;
        end else begin
            lat_q  <= lat_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Arbiter sharing one external memory port between I-cache refills and
// D-cache refills/write-backs. Each grant runs a full line burst; D wins ties
// until it has taken MAX_D_STREAK consecutive grants over a waiting I side.
module mem_refill_arbiter
    import mem_refill_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS   = 4,
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned MAX_D_STREAK = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [31:0]                   i_addr,
    output logic [31:0]                   i_rdata,
    output logic                          i_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] i_beat,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [31:0]                   d_addr,
    input  logic [31:0]                   d_wdata,
    output logic [31:0]                   d_rdata,
    output logic                          d_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] d_beat,
    output logic                          d_done,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          mem_wb,
    input  logic [31:0]                   mem_rdata
);

    localparam int unsigned BEAT_W   = $clog2(LINE_WORDS);
    localparam int unsigned STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

    state_e              state_q;
    owner_e              owner_q;
    logic [31:0]         base_q;
    logic                we_q;
    logic [STREAK_W-1:0] streak_q;
    logic [31:0]         rdata_q;
    logic [BEAT_W-1:0]   rbeat_q;
    logic                i_rvalid_q, d_rvalid_q;
    logic                i_done_q, d_done_q;

    logic                grant_i, grant_d, streak_max;
    logic                seq_start, in_xfer;
    logic [BEAT_W-1:0]   beat;
    logic                last_cyc, last_beat;

    // Grant decision: a lone request wins; on a tie D wins unless it has
    // already used up its streak while I was waiting.
    always_comb begin
        streak_max = (streak_q == STREAK_W'(MAX_D_STREAK));
        grant_i    = i_req && (!d_req || streak_max);
        grant_d    = d_req && !grant_i;
    end

    assign in_xfer   = (state_q == XFER);
    assign seq_start = (state_q == IDLE) && (grant_i || grant_d);

    mem_beat_seq #(
        .LINE_WORDS (LINE_WORDS),
        .MEM_LAT    (MEM_LAT)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .start_i     (seq_start),
        .en_i        (in_xfer),
        .beat_o      (beat),
        .last_cyc_o  (last_cyc),
        .last_beat_o (last_beat)
    );

    // Arbitration FSM with registered return-path and done outputs. Read
    // data is not reset: it is only visible while a valid flag is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            we_q       <= 1'b0;
            streak_q   <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        owner_q  <= OWN_I;
                        base_q   <= line_base(i_addr, LINE_WORDS);
                        we_q     <= 1'b0;
                        streak_q <= '0;
                        state_q  <= XFER;
                    end else if (grant_d) begin
                        owner_q <= OWN_D;
                        base_q  <= line_base(d_addr, LINE_WORDS);
                        we_q    <= d_we;
                        state_q <= XFER;
                        if (!i_req) begin
                            streak_q <= '0;
                        end else if (!streak_max) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else begin
                        // No request at all, so I is not waiting either.
                        streak_q <= '0;
                    end
                end
                XFER: begin
                    if (last_cyc) begin
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                            rbeat_q <= beat;
                            if (owner_q == OWN_I) begin
                                i_rvalid_q <= 1'b1;
                            end else begin
                                d_rvalid_q <= 1'b1;
                            end
                        end
                        if (last_beat) begin
                            state_q <= DONE;
                            if (owner_q == OWN_I) begin
                                i_done_q <= 1'b1;
                            end else begin
                                d_done_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // Grant is deliberately skipped here so the requester can
                    // see done and drop its request first.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory port drive: only active during XFER; the write strobe lands on
    // the last cycle of each beat so the word address has settled.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wb    = 1'b0;
        if (in_xfer) begin
            mem_addr  = base_q + {{(32 - BEAT_W - WORD_OFF_W){1'b0}}, beat, 2'b00};
            mem_wdata = d_wdata;
            mem_wb    = (owner_q == OWN_D) && we_q && last_cyc;
        end
    end

    // Requester-side outputs: the beat index follows the returned word when
    // a valid is shown, else the live beat of the owner's transfer.
    always_comb begin
        i_rvalid = i_rvalid_q;
        d_rvalid = d_rvalid_q;
        i_done   = i_done_q;
        d_done   = d_done_q;
        i_rdata  = i_rvalid_q ? rdata_q : '0;
        d_rdata  = d_rvalid_q ? rdata_q : '0;
        i_beat   = '0;
        d_beat   = '0;
        if (i_rvalid_q) begin
            i_beat = rbeat_q;
        end else if (in_xfer && (owner_q == OWN_I)) begin
            i_beat = beat;
        end
        if (d_rvalid_q) begin
            d_beat = rbeat_q;
        end else if (in_xfer && (owner_q == OWN_D)) begin
            d_beat = beat;
        end
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter with a cycle-stamped scoreboard of
// expected read returns, write strobes and done pulses.
module tb_mem_refill_arbiter;

    localparam int LW = 4;
    localparam int ML = 2;

    typedef struct {
        int          cyc;
        bit          side;   // 1 = D, 0 = I
        int          beat;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_rvalid, i_done, d_rvalid, d_done, mem_wb;
    logic [1:0]  i_beat, d_beat;

    logic        d2_req = 1'b0;
    logic [31:0] d2_addr = '0, mem2_rdata, i2_rdata, d2_rdata, mem2_addr, mem2_wdata;
    logic        i2_rvalid, i2_done, d2_rvalid, d2_done, mem2_wb;
    logic [0:0]  i2_beat, d2_beat;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  idone_cnt = 0, ddone_cnt = 0;
    bit  quiet_i = 0, quiet_d = 0;
    ev_t rq[$];
    ev_t wq[$];
    ev_t dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rdata  = mem_word(mem_addr);
    assign mem2_rdata = mem_word(mem2_addr);
    assign d_wdata    = 32'hA0 + 32'(d_beat);

    mem_refill_arbiter #(.LINE_WORDS(4), .MEM_LAT(2), .MAX_D_STREAK(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .i_beat(i_beat), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_beat(d_beat), .d_done(d_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wb(mem_wb), .mem_rdata(mem_rdata)
    );

    mem_refill_arbiter #(.LINE_WORDS(2), .MEM_LAT(1), .MAX_D_STREAK(3)) dut2 (
        .clk(clk), .rst(rst),
        .i_req(1'b0), .i_addr(32'h0), .i_rdata(i2_rdata), .i_rvalid(i2_rvalid),
        .i_beat(i2_beat), .i_done(i2_done),
        .d_req(d2_req), .d_we(1'b0), .d_addr(d2_addr), .d_wdata(32'h0),
        .d_rdata(d2_rdata), .d_rvalid(d2_rvalid), .d_beat(d2_beat), .d_done(d2_done),
        .mem_addr(mem2_addr), .mem_wdata(mem2_wdata), .mem_wb(mem2_wb), .mem_rdata(mem2_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_i"}, i_rdata | 32'(i_rvalid) | 32'(i_beat) | 32'(i_done), 0);
        chk({tag, "_d"}, d_rdata | 32'(d_rvalid) | 32'(d_beat) | 32'(d_done), 0);
        chk({tag, "_mem"}, mem_addr | mem_wdata | 32'(mem_wb), 0);
    endtask

    // Expected events of one full burst granted in cycle t.
    task automatic push_burst(input bit side, input bit we, input logic [31:0] base, input int t);
        for (int k = 0; k < LW; k++) begin
            if (we) wq.push_back('{t + ML * (k + 1), side, k, base + 32'(4 * k), 32'hA0 + 32'(k)});
            else    rq.push_back('{t + ML * (k + 1) + 1, side, k, base + 32'(4 * k),
                                   mem_word(base + 32'(4 * k))});
        end
        dq.push_back('{t + LW * ML + 1, side, 0, 32'h0, 32'h0});
    endtask

    // Raise a request at the current cycle, follow the burst, drop on done.
    task automatic burst(input bit side, input bit we, input logic [31:0] addr, input bit chk_addr);
        int          t0;
        logic [31:0] base;
        base = addr & ~32'hF;
        t0   = cyc;
        if (side) begin d_req = 1'b1; d_addr = addr; d_we = we; end
        else begin i_req = 1'b1; i_addr = addr; end
        push_burst(side, we, base, t0);
        for (int n = 1; n <= LW * ML + 2; n++) begin
            @(negedge clk);
            if (chk_addr)
                chk("mem_addr", mem_addr, (n <= LW * ML) ? base + 32'(4 * ((n - 1) / ML)) : 32'h0);
            if (n == LW * ML + 1) begin
                if (side) d_req = 1'b0; else i_req = 1'b0;
            end
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        ev_t e;
        if (i_rvalid || d_rvalid) begin
            if (rq.size() == 0) chk("rvalid_unexpected", 32'({i_rvalid, d_rvalid}), 0);
            else begin
                e = rq.pop_front();
                chk("rv_cyc", cyc, e.cyc);
                chk("rv_side", 32'({i_rvalid, d_rvalid}), e.side ? 32'd1 : 32'd2);
                chk("rv_beat", 32'(e.side ? d_beat : i_beat), e.beat);
                chk("rv_data", e.side ? d_rdata : i_rdata, e.data);
            end
        end
        if (mem_wb) begin
            if (wq.size() == 0) chk("wb_unexpected", 32'(mem_wb), 0);
            else begin
                e = wq.pop_front();
                chk("wb_cyc", cyc, e.cyc);
                chk("wb_addr", mem_addr, e.addr);
                chk("wb_data", mem_wdata, e.data);
            end
        end
        if (i_done) idone_cnt++;
        if (d_done) ddone_cnt++;
        if (i_done || d_done) begin
            if (dq.size() == 0) chk("done_unexpected", 32'({i_done, d_done}), 0);
            else begin
                e = dq.pop_front();
                chk("done_cyc", cyc, e.cyc);
                chk("done_side", 32'({i_done, d_done}), e.side ? 32'd1 : 32'd2);
            end
        end
        if (quiet_i) chk("i_quiet", i_rdata | 32'(i_rvalid) | 32'(i_beat) | 32'(i_done), 0);
        if (quiet_d) chk("d_quiet", d_rdata | 32'(d_rvalid) | 32'(d_beat) | 32'(d_done), 0);
    end

    initial begin
        int t0, i0, d0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // D read of line 0x100
        quiet_i = 1;
        burst(1'b1, 1'b0, 32'h0000_010C, 1'b1);

        // D write-back of line 0x200
        burst(1'b1, 1'b1, 32'h0000_020C, 1'b1);
        quiet_i = 0;

        // I read alone; D side must stay silent
        quiet_d = 1;
        burst(1'b0, 1'b0, 32'h0000_4000, 1'b1);
        quiet_d = 0;

        // Both held: D, D, D, I, D, D, D, I
        t0 = cyc; i0 = idone_cnt; d0 = ddone_cnt;
        i_req = 1'b1; i_addr = 32'h0000_0800;
        d_req = 1'b1; d_addr = 32'h0000_0904; d_we = 1'b0;
        for (int k = 0; k < 8; k++)
            push_burst((k % 4) != 3, 1'b0, ((k % 4) != 3) ? 32'h900 : 32'h800, t0 + 10 * k);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 79) begin i_req = 1'b0; d_req = 1'b0; end
        end
        chk("i_done_count", idone_cnt - i0, 2);
        chk("d_done_count", ddone_cnt - d0, 6);

        // Reset in beat 2 of a D read aborts it; the held request restarts
        t0 = cyc;
        d_req = 1'b1; d_addr = 32'h0000_030C; d_we = 1'b0;
        rq.push_back('{t0 + 3, 1'b1, 0, 32'h300, mem_word(32'h300)});
        rq.push_back('{t0 + 5, 1'b1, 1, 32'h304, mem_word(32'h304)});
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_abort");
        rst = 1'b1;
        burst(1'b1, 1'b0, 32'h0000_030C, 1'b1);

        // Short configuration: LINE_WORDS=2, MEM_LAT=1
        d2_req = 1'b1; d2_addr = 32'h0000_0506;
        @(negedge clk);
        chk("l2_addr0", mem2_addr, 32'h500);
        chk("l2_rv0", 32'(d2_rvalid), 0);
        @(negedge clk);
        chk("l2_addr1", mem2_addr, 32'h504);
        chk("l2_rv1", 32'(d2_rvalid), 1);
        chk("l2_beat1", 32'(d2_beat), 0);
        chk("l2_data1", d2_rdata, mem_word(32'h500));
        @(negedge clk);
        chk("l2_done", 32'(d2_done), 1);
        chk("l2_beat2", 32'(d2_beat), 1);
        chk("l2_data2", d2_rdata, mem_word(32'h504));
        chk("l2_addr2", mem2_addr, 32'h0);
        d2_req = 1'b0;
        @(negedge clk);
        chk("l2_idle", 32'(d2_done) | 32'(d2_rvalid) | mem2_addr, 0);
        chk("l2_i_quiet", i2_rdata | 32'(i2_rvalid) | 32'(i2_beat) | 32'(i2_done)
                          | mem2_wdata | 32'(mem2_wb), 0);

        repeat (3) @(negedge clk);
        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares the single external memory port (MemAddr/MemWriteData/MemWb/MemData) between the instruction-cache refill side (I) and the data-cache refill/write-back side (D).
- Each granted transaction is a line burst of LINE_WORDS words.
- External memory has a fixed per-word latency; the block sequences the addresses, write strobes and read-data returns.
- Sits between ICache/DCache and the external memory, below the IF and MEM stages.

Parameters:
- LINE_WORDS, 4, words per cache line / burst; power of two, at least 2.
- MEM_LAT, 2, cycles each word's address is held on the memory port; at least 1.
- MAX_D_STREAK, 3, consecutive D grants allowed while i_req is pending before I is forced.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- i_req  in  1  I-side read-burst request; level, held until i_done.
- i_addr  in  32  I-side line address; low offset bits are ignored.
- i_rdata  out  32  returned word.
- i_rvalid  out  1  one-cycle pulse per returned word.
- i_beat  out  log2(LINE_WORDS)  index of the word in i_rdata.
- i_done  out  1  one-cycle pulse when the I burst completes.
- d_req  in  1  D-side request; level, held until d_done.
- d_we  in  1  1 = write-back burst, 0 = read burst; sampled at grant.
- d_addr  in  32  D-side line address.
- d_wdata  in  32  write word for the current d_beat; must be stable while d_beat is unchanged.
- d_rdata  out  32  returned word.
- d_rvalid  out  1  one-cycle pulse per returned word; read bursts only.
- d_beat  out  log2(LINE_WORDS)  current beat index during D transfers; returned-word index on d_rvalid.
- d_done  out  1  one-cycle pulse when the D burst completes.
- mem_addr  out  32  word address to memory.
- mem_wdata  out  32  write data to memory.
- mem_wb  out  1  memory write strobe.
- mem_rdata  in  32  memory read data; valid in the last cycle of each beat.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0; streak counter, beat counter and latency counter are 0.
  - A transfer in progress is aborted; no done pulse is produced for it.
- States: IDLE, XFER, DONE.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant D unless streak equals MAX_D_STREAK, in which case grant I.
  - On grant: latch owner, line base (addr with low log2(LINE_WORDS)+2 bits cleared) and d_we; go to XFER next cycle.
  - No request: stay in IDLE.
- Streak counter:
  - Increments on each D grant made while i_req is high, saturating at MAX_D_STREAK.
  - Clears on any I grant, and whenever i_req is low in IDLE.
- XFER:
  - Beat k drives mem_addr = base + 4k for MEM_LAT consecutive cycles.
  - mem_wdata = d_wdata; mem_wb = 1 only in the last cycle of beat k, and only for a D write.
  - For reads, mem_rdata is captured in the last cycle of beat k. The owner's rdata, rvalid and beat outputs are registered and appear the following cycle.
  - After the last cycle of beat LINE_WORDS-1, go to DONE.
- DONE:
  - Lasts one cycle. The owner's done pulses here, coincident with the final rvalid for reads.
  - No grant is evaluated in DONE, so the requester sees done and drops req before the next IDLE.
  - Then go to IDLE.
- Outside XFER: mem_addr and mem_wdata are 0 and mem_wb is 0.
- Non-owner outputs stay 0 at all times.
- Total burst latency: grant cycle t, XFER from t+1 to t+LINE_WORDS·MEM_LAT, done at t+LINE_WORDS·MEM_LAT+1.
- Request dropped mid-burst: protocol violation. The burst still completes and done still pulses.
- Address arithmetic wraps modulo 2^32.
- Beat counter wraps only at burst end.

Decomposition:
- Shared header/package holds:
  - State encodings IDLE/XFER/DONE.
  - Owner encoding OWN_I/OWN_D.
  - Offset-width constant derived from LINE_WORDS.
- One natural sub-module, mem_beat_seq:
  - Contains the latency and beat counters.
  - Takes a start input.
  - Produces beat index, last-cycle-of-beat and last-beat flags.

Test Plan:
- Defaults, D read, d_addr=0x10C requested at cycle 0:
  - mem_addr = 0x100 in cycles 1–2, 0x104 in 3–4, 0x108 in 5–6, 0x10C in 7–8.
  - d_rvalid in cycles 3, 5, 7, 9 with d_beat 0..3.
  - d_done at cycle 9; IDLE at cycle 10.
- D write, base 0x200, d_wdata = 0xA0+d_beat:
  - mem_wb high only in cycles 2, 4, 6, 8, with mem_wdata 0xA0..0xA3 at addresses 0x200..0x20C.
  - No d_rvalid; d_done at cycle 9.
- i_req and d_req both held continuously:
  - Grant order D, D, D, I, D, D, D, I.
  - i_done once per four bursts.
- i_req alone, i_addr=0x4000:
  - i_rvalid returns memory words in order.
  - d_* outputs stay 0 throughout.
- rst driven low during beat 2 of a D read:
  - Next cycle all outputs are 0, with no d_done.
  - After release with d_req still high, the burst restarts at beat 0.
- MEM_LAT=1, LINE_WORDS=2:
  - mem_addr changes every cycle.
  - done arrives 3 cycles after grant.
